// File: rtl/prio_arb_pkg.sv
// -----------------------------------------------------------------------------
// prio_arb_pkg
//   Shared definitions for the sequential priority arbiter:
//     - state_t    : arbiter FSM encoding (IDLE, GRANT)
//     - MODE_FIXED : highest requesting index wins
//     - MODE_RR    : round-robin rotation starting at the pointer
//     - clog2()    : index width helper, never less than 1
// -----------------------------------------------------------------------------
package prio_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/priority_arbiter_seq_pick.sv
// -----------------------------------------------------------------------------
// priority_pick
//   Purely combinational picker used by priority_arbiter_seq.
//   Ports:
//     req  [N] in  : request vector
//     ptr  [W] in  : round-robin start index (always < N)
//     mode     in  : MODE_FIXED or MODE_RR
//     any      out : at least one request is set
//     idx  [W] out : chosen index (0 when any=0)
// -----------------------------------------------------------------------------
module priority_pick
    import prio_arb_pkg::*;
#(
    parameter int N = 10,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic         any,
    output logic [W-1:0] idx
);

    int w_pos;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    always_comb begin
        any   = |req;
        idx   = '0;
        w_pos = 0;
        if (mode == MODE_FIXED) begin
            // Ascending scan: the last (highest) set bit overwrites earlier ones.
            for (int i = 0; i < N; i++) begin
                if (req[i]) idx = W'(i);
            end
        end else begin
            // Descending offset scan from ptr so the smallest offset wins;
            // the wrap is done by subtraction because N need not be 2**W.
            for (int k = N - 1; k >= 0; k--) begin
                w_pos = int'(ptr) + k;
                if (w_pos >= N) w_pos = w_pos - N;
                if (req[w_pos]) idx = W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_seq.sv
// -----------------------------------------------------------------------------
// priority_arbiter_seq
//   Registered N-way arbiter presenting the winning index under valid/ready.
//   Fixed-priority (index N-1 highest) or round-robin, chosen by mode at each
//   load point. Grants are never revoked; back-to-back grants have no bubble.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     req        [N]  : request vector
//     mode            : 0 fixed, 1 round-robin
//     out_ready       : consumer accepts the current grant
//     lock            : only with PRIO_ARB_LOCK_EN; keeps re-granting the
//                       current index while it stays requested
//     out_valid       : a grant is held
//     out_idx    [W]  : binary index of the grant
//     out_onehot [N]  : one-hot form of out_idx, zero while out_valid=0
//   Configuration macro: PRIO_ARB_LOCK_EN
// -----------------------------------------------------------------------------
module priority_arbiter_seq
    import prio_arb_pkg::*;
#(
    parameter int N = 10,
    parameter int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
`ifdef PRIO_ARB_LOCK_EN
    input  logic         lock,
`endif
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_idx;
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_ptr_adv;
    logic [W-1:0] w_ptr_pick;
    logic [W-1:0] w_pick_idx;
    logic [W-1:0] w_lock_idx;
    logic         w_pick_any;
    logic         w_hs;
    logic         w_load;
    logic         w_force;

    assign w_hs = (r_state == GRANT) && out_ready;

`ifdef PRIO_ARB_LOCK_EN
    logic         r_lock;
    logic [W-1:0] r_lock_idx;

    assign w_lock_idx = r_lock ? r_lock_idx : r_idx;
    // Holding the lock requires the locked requester to still be asking.
    assign w_force    = w_hs && lock && req[w_lock_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_hs) begin
            r_lock     <= w_force;
            r_lock_idx <= w_lock_idx;
        end
    end
`else
    assign w_lock_idx = r_idx;
    assign w_force    = 1'b0;
`endif

    // Pointer after a handshake; the explicit wrap keeps it below N.
    assign w_ptr_adv  = w_force ? r_ptr :
                        ((r_idx == LAST_IDX) ? '0 : r_idx + 1'b1);
    // A winner loaded at a handshake must see the already-advanced pointer.
    assign w_ptr_pick = w_hs ? w_ptr_adv : r_ptr;

    priority_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req  (req),
        .ptr  (w_ptr_pick),
        .mode (mode),
        .any  (w_pick_any),
        .idx  (w_pick_idx)
    );

    assign w_load = w_pick_any && ((r_state == IDLE) || w_hs);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_any)         w_state_next = GRANT;
            GRANT:   if (w_hs && !w_pick_any) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_ptr <= '0;
        end else begin
            if (w_hs)   r_ptr <= w_ptr_adv;
            if (w_load) r_idx <= w_force ? w_lock_idx : w_pick_idx;
        end
    end

    always_comb begin
        out_valid  = (r_state == GRANT);
        out_idx    = r_idx;
        out_onehot = '0;
        if (r_state == GRANT) out_onehot = {{(N-1){1'b0}}, 1'b1} << r_idx;
    end

endmodule

// File: tb/tb_priority_arbiter_seq.sv
module tb_priority_arbiter_seq;

    localparam int N = 10;
    localparam int W = 4;
`ifdef PRIO_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         lock;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;

    int errors = 0;
    int checks = 0;

    // Reference model state, advanced once per clock edge.
    bit m_valid;
    int m_idx;
    int m_ptr;

    priority_arbiter_seq #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .out_ready  (out_ready),
`ifdef PRIO_ARB_LOCK_EN
        .lock       (lock),
`endif
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Fixed: highest set index. Round-robin: first set index at or after p.
    function automatic int model_pick(input logic [N-1:0] r, input logic m, input int p);
        if (!m) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] exp_oh;
        exp_oh = m_valid ? (32'd1 << m_idx) : 32'd0;
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".onehot"}, 32'(out_onehot), exp_oh);
        if (m_valid) check({tag, ".idx"}, 32'(out_idx), 32'(m_idx));
    endtask

    // Called just after a falling edge: drive, update model, check after the rising edge.
    task automatic step(input logic [N-1:0] r, input logic m, input logic rdy,
                        input logic lk, input string tag);
        req = r; mode = m; out_ready = rdy; lock = lk;
        if (!m_valid) begin
            if (r != '0) begin
                m_idx   = model_pick(r, m, m_ptr);
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            if (!(LOCK_EN && lk && r[m_idx])) begin
                m_ptr = (m_idx + 1) % N;
                if (r != '0) m_idx = model_pick(r, m, m_ptr);
                else         m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".idx"}, 32'(out_idx), 32'd0);
        check({tag, ".onehot"}, 32'(out_onehot), 32'd0);
        m_valid = 1'b0; m_idx = 0; m_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        rst = 1'b1; req = '0; mode = 1'b0; out_ready = 1'b0; lock = 1'b0;
        m_valid = 1'b0; m_idx = 0; m_ptr = 0;
        repeat (2) @(negedge clk);
        check("por.valid", 32'(out_valid), 32'd0);
        check("por.idx", 32'(out_idx), 32'd0);
        check("por.onehot", 32'(out_onehot), 32'd0);
        rst = 1'b0;

        // Fixed priority: 9 beats 4, then 4 once 9 leaves.
        step(10'b1000010000, 1'b0, 1'b1, 1'b0, "fix1");
        check("fix1.const", 32'(out_idx), 32'd9);
        step(10'b0000010000, 1'b0, 1'b1, 1'b0, "fix2");
        check("fix2.const", 32'(out_idx), 32'd4);
        // Handshake with no requests -> IDLE; out_ready in IDLE is ignored.
        step('0, 1'b0, 1'b1, 1'b0, "idle1");
        step('0, 1'b0, 1'b1, 1'b0, "idle2");
        check("idle2.const", 32'(out_valid), 32'd0);

        // Reset asserted while a grant is held.
        step(10'b0000000100, 1'b0, 1'b0, 1'b0, "pre_rst");
        do_reset("rst_mid");

        // Round-robin rotation 0,4,7,0,4,7.
        for (int k = 0; k < 6; k++) begin
            step(10'b0010010001, 1'b1, 1'b1, 1'b0, "rr");
            check("rr.const", 32'(out_idx), (k % 3 == 0) ? 32'd0 : (k % 3 == 1) ? 32'd4 : 32'd7);
        end

        // Backpressure: grant 7 held while req churns and req[7] drops.
        for (int k = 0; k < 5; k++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            r[7] = 1'b0;
            step(r, 1'b1, 1'b0, 1'b0, "bp");
            check("bp.hold", 32'(out_idx), 32'd7);
        end
        step(10'b0000010001, 1'b1, 1'b1, 1'b0, "bp_hs");
        check("bp_hs.const", 32'(out_idx), 32'd0);
        step(10'b0000010001, 1'b1, 1'b0, 1'b0, "bp_after");
        check("bp_after.const", 32'(out_idx), 32'd0);

        // Pointer wrap from 9 to 0.
        do_reset("rst_wrap");
        step(10'b0100000000, 1'b1, 1'b0, 1'b0, "wrap0");
        step(10'b1000000100, 1'b1, 1'b1, 1'b0, "wrap1");
        check("wrap1.const", 32'(out_idx), 32'd9);
        step(10'b1000000100, 1'b1, 1'b1, 1'b0, "wrap2");
        check("wrap2.const", 32'(out_idx), 32'd2);

        // Lock: 0 repeats while locked, otherwise 0,4 alternate.
        do_reset("rst_lock");
        for (int k = 0; k < 4; k++) begin
            step(10'b0000010001, 1'b1, 1'b1, 1'b1, "lock");
            check("lock.const", 32'(out_idx), (LOCK_EN || k % 2 == 0) ? 32'd0 : 32'd4);
        end
        step(10'b0000010000, 1'b1, 1'b1, 1'b1, "lock_drop");
        check("lock_drop.const", 32'(out_idx), 32'd4);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 1) == 0) r = r & N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 7) == 0) r = '0;
            step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
